// File: rtl/l2_write_buffer.sv
// l2_write_buffer: dirty-line FIFO between L2 and memory; reads bypass queued writebacks.
// Optional macro WB_READ_FORWARD_EN: serve read hits straight from the buffer instead of draining first.
module l2_write_buffer #(
    parameter int DEPTH    = 4,
    parameter int OFFSET_W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [15:0]  mem_address,
    input  logic [127:0] mem_wdata,
    output logic [127:0] mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic         buf_full,
    output logic         buf_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int TW = 16 - OFFSET_W;
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);
    localparam logic [PW:0] ONE = (PW + 1)'(1);

    typedef enum logic [1:0] {IDLE, RD_MEM, WR_MEM, RESP} state_t;

    state_t           state;
    logic [DEPTH-1:0] valid;
    logic [TW-1:0]    tags  [DEPTH];
    logic [127:0]     lines [DEPTH];
    logic [PW-1:0]    head, tail, hidx;
    logic [PW:0]      count;
    logic [TW-1:0]    req_tag;
    logic             hit;
    logic             unused_offset;

    assign req_tag = mem_address[15:OFFSET_W];
    assign unused_offset = ^mem_address[OFFSET_W-1:0];

    // Find the single valid entry holding the requested line, if any
    always_comb begin
        hit = 1'b0;
        hidx = '0;
        for (int i = 0; i < DEPTH; i++)
            if (valid[i] && tags[i] == req_tag) begin
                hit = 1'b1;
                hidx = PW'(i);
            end
    end

    // Arbitration (write, then read, then drain), memory handshakes and FIFO bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            valid <= '0;
            head <= '0;
            tail <= '0;
            count <= '0;
            mem_resp <= 1'b0;
            pmem_read <= 1'b0;
            pmem_write <= 1'b0;
            mem_rdata <= '0;
            pmem_address <= '0;
            pmem_wdata <= '0;
            buf_full <= 1'b0;
            buf_empty <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                tags[i] <= '0;
                lines[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (mem_write && (hit || !buf_full)) begin
                        if (hit)
                            lines[hidx] <= mem_wdata;
                        else begin
                            valid[tail] <= 1'b1;
                            tags[tail] <= req_tag;
                            lines[tail] <= mem_wdata;
                            tail <= tail + 1'b1;
                            count <= count + 1'b1;
                            buf_full <= count == FULL - ONE;
                            buf_empty <= 1'b0;
                        end
                        mem_resp <= 1'b1;
                        state <= RESP;
                    end else if (mem_read && !mem_write && !hit) begin
                        pmem_address <= {req_tag, {OFFSET_W{1'b0}}};
                        pmem_read <= 1'b1;
                        state <= RD_MEM;
                    end
`ifdef WB_READ_FORWARD_EN
                    else if (mem_read && !mem_write) begin
                        mem_rdata <= lines[hidx];
                        mem_resp <= 1'b1;
                        state <= RESP;
                    end
`endif
                    else if (!buf_empty && !(mem_read && mem_write)) begin
                        pmem_address <= {tags[head], {OFFSET_W{1'b0}}};
                        pmem_wdata <= lines[head];
                        pmem_write <= 1'b1;
                        state <= WR_MEM;
                    end
                end
                RD_MEM: begin
                    if (pmem_resp) begin
                        mem_rdata <= pmem_rdata;
                        pmem_read <= 1'b0;
                        mem_resp <= 1'b1;
                        state <= RESP;
                    end
                end
                WR_MEM: begin
                    if (pmem_resp) begin
                        pmem_write <= 1'b0;
                        valid[head] <= 1'b0;
                        head <= head + 1'b1;
                        count <= count - 1'b1;
                        buf_full <= 1'b0;
                        buf_empty <= count == ONE;
                        state <= IDLE;
                    end
                end
                RESP: begin
                    mem_resp <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_l2_write_buffer.sv
// tb_l2_write_buffer: directed plus randomized bench for l2_write_buffer against a queue/array model
module tb_l2_write_buffer;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [15:0]  mem_address = '0;
    logic [127:0] mem_wdata = '0;
    logic [127:0] mem_rdata;
    logic         mem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;
    logic         buf_full;
    logic         buf_empty;

    int vectors = 0;
    int miscompares = 0;
    int hold = 1;
    int lat = 1;
    int npread = 0;

    typedef struct {
        logic [11:0]  t;
        logic [127:0] d;
    } ent_t;

    ent_t         q[$];
    logic [127:0] memv [logic [11:0]];

    l2_write_buffer dut (
        .clk(clk), .reset_n(reset_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .buf_full(buf_full), .buf_empty(buf_empty)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (pmem_read) npread++;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int find(input logic [11:0] t);
        foreach (q[i]) if (q[i].t == t) return i;
        return -1;
    endfunction

    function automatic logic [127:0] bmem(input logic [11:0] t);
        return memv.exists(t) ? memv[t] : {8{4'hC, t}};
    endfunction

    function automatic logic [127:0] latest(input logic [11:0] t);
        int k;
        k = find(t);
        return k >= 0 ? q[k].d : bmem(t);
    endfunction

    // Memory: answers each strobe after lat cycles and scores drain order/content
    initial begin : responder
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (pmem_resp || !reset_n) begin
                pmem_resp = 1'b0;
                cnt = 0;
            end else if (hold == 0 && (pmem_read || pmem_write)) begin
                if (cnt < lat) cnt++;
                else begin
                    cnt = 0;
                    pmem_resp = 1'b1;
                    check("pmem_one_strobe", {127'b0, pmem_read & pmem_write}, 128'b0);
                    check("pmem_addr_low", {124'b0, pmem_address[3:0]}, 128'b0);
                    if (pmem_write) begin
                        if (q.size() == 0) check("pmem_wr_spurious", 128'd1, 128'd0);
                        else begin
                            check("pmem_wr_addr", {116'b0, pmem_address[15:4]}, {116'b0, q[0].t});
                            check("pmem_wr_data", pmem_wdata, q[0].d);
                            memv[q[0].t] = q[0].d;
                            void'(q.pop_front());
                        end
                    end else begin
                        check("pmem_rd_stale", {127'b0, find(pmem_address[15:4]) >= 0}, 128'b0);
                        pmem_rdata = bmem(pmem_address[15:4]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_resp(output int cyc, output int pr);
        cyc = 0;
        pr = -1;
        do begin
            tick();
            cyc++;
            if (!mem_resp && pmem_resp) pr = cyc;
        end while (!mem_resp && cyc < 400);
        if (!mem_resp) begin
            check("resp_timeout", 128'd0, 128'd1);
            cyc = -1;
        end
    endtask

    task automatic status();
        check("buf_full", {127'b0, buf_full}, {127'b0, q.size() == DEPTH});
        check("buf_empty", {127'b0, buf_empty}, {127'b0, q.size() == 0});
    endtask

    task automatic accept_write(input logic [15:0] a, input logic [127:0] d);
        int k;
        k = find(a[15:4]);
        if (k >= 0) q[k].d = d;
        else q.push_back('{a[15:4], d});
        status();
    endtask

    task automatic do_write(input logic [15:0] a, input logic [127:0] d, output int cyc);
        int pr;
        tick();
        mem_address = a;
        mem_wdata = d;
        mem_write = 1'b1;
        wait_resp(cyc, pr);
        mem_write = 1'b0;
        if (cyc > 0) accept_write(a, d);
    endtask

    task automatic do_read(input logic [15:0] a, output int cyc, output int pr);
        tick();
        mem_address = a;
        mem_read = 1'b1;
        wait_resp(cyc, pr);
        mem_read = 1'b0;
        if (cyc > 0) begin
            check("rd_data", mem_rdata, latest(a[15:4]));
            status();
        end
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (!(buf_empty && !pmem_write) && n < 400) begin
            tick();
            n++;
        end
        check("drained", {127'b0, buf_empty}, 128'd1);
        check("model_drained", 128'(q.size()), 128'd0);
    endtask

    task automatic wait_pwrite();
        int n;
        n = 0;
        while (!pmem_write && n < 10) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int cyc, pr, n0;
        logic [15:0] a;
        #1 reset_n = 1'b0;
        repeat (2) tick();
        check("rst_mem_resp", {127'b0, mem_resp}, 128'd0);
        check("rst_pmem_read", {127'b0, pmem_read}, 128'd0);
        check("rst_pmem_write", {127'b0, pmem_write}, 128'd0);
        check("rst_mem_rdata", mem_rdata, 128'd0);
        check("rst_pmem_address", {112'b0, pmem_address}, 128'd0);
        check("rst_pmem_wdata", pmem_wdata, 128'd0);
        check("rst_buf_full", {127'b0, buf_full}, 128'd0);
        check("rst_buf_empty", {127'b0, buf_empty}, 128'd1);
        reset_n = 1'b1;

        hold = 1;
        do_write(16'h1230, {4{32'hAAAA_0001}}, cyc);
        wait_pwrite();
        check("t1_drain_started", {127'b0, pmem_write}, 128'd1);
        reset_n = 1'b0;
        #1;
        check("t1_rst_pmem_write", {127'b0, pmem_write}, 128'd0);
        check("t1_rst_buf_empty", {127'b0, buf_empty}, 128'd1);
        q.delete();
        tick();
        reset_n = 1'b1;
        hold = 0;
        n0 = 0;
        repeat (4) begin
            tick();
            n0 += int'(mem_resp);
        end
        check("t1_no_resp", 128'(n0), 128'd0);

        hold = 1;
        do_write(16'h1230, {4{32'hAAAA_AAAA}}, cyc);
        check("t2_lat_a", 128'(cyc), 128'd1);
        do_write(16'h4560, {4{32'hBBBB_BBBB}}, cyc);
        check("t2_lat_b", 128'(cyc), 128'd1);
        hold = 0;
        wait_empty();

        hold = 1;
        for (int i = 1; i <= 4; i++) begin
            do_write(16'(i * 16), {4{32'(32'h1111_1111 * i)}}, cyc);
            check("t3_lat", 128'(cyc), 128'd1);
        end
        tick();
        mem_address = 16'h0050;
        mem_wdata = {4{32'h5555_5555}};
        mem_write = 1'b1;
        n0 = 0;
        repeat (5) begin
            tick();
            n0 += int'(mem_resp);
        end
        check("t3_stall_no_resp", 128'(n0), 128'd0);
        check("t3_full", {127'b0, buf_full}, 128'd1);
        check("t3_drain_wr", {127'b0, pmem_write}, 128'd1);
        check("t3_drain_addr", {112'b0, pmem_address}, 128'h0010);
        hold = 0;
        wait_resp(cyc, pr);
        mem_write = 1'b0;
        hold = 1;
        if (cyc > 0) accept_write(16'h0050, {4{32'h5555_5555}});

        do_write(16'h0020, {4{32'hCCCC_CCCC}}, cyc);
        check("t4_lat", 128'(cyc), 128'd1);
        check("t4_still_full", {127'b0, buf_full}, 128'd1);
        wait_pwrite();
        check("t4_drain_addr", {112'b0, pmem_address}, 128'h0020);
        check("t4_drain_data", pmem_wdata, {4{32'hCCCC_CCCC}});
        hold = 0;
        wait_empty();

        hold = 1;
        do_write(16'h1000, {4{32'hD1D1_D1D1}}, cyc);
        do_write(16'h2000, {4{32'hD2D2_D2D2}}, cyc);
        tick();
        mem_address = 16'h8000;
        mem_read = 1'b1;
        tick();
        check("t5_pread", {127'b0, pmem_read}, 128'd1);
        check("t5_no_pwrite", {127'b0, pmem_write}, 128'd0);
        check("t5_paddr", {112'b0, pmem_address}, 128'h8000);
        hold = 0;
        wait_resp(cyc, pr);
        mem_read = 1'b0;
        check("t5_lat", 128'(cyc - pr), 128'd1);
        check("t5_data", mem_rdata, bmem(12'h800));
        wait_empty();

`ifdef WB_READ_FORWARD_EN
        hold = 1;
`else
        hold = 0;
`endif
        do_write(16'h1230, {4{32'hA2A2_A2A2}}, cyc);
        n0 = npread;
        do_read(16'h1230, cyc, pr);
`ifdef WB_READ_FORWARD_EN
        check("t6_fwd_lat", 128'(cyc), 128'd1);
        check("t6_no_pread", 128'(npread), 128'(n0));
        hold = 0;
`else
        check("t6_pread_issued", {127'b0, npread > n0}, 128'd1);
`endif
        wait_empty();

        reset_n = 1'b0;
        q.delete();
        tick();
        reset_n = 1'b1;
        hold = 0;
        for (int it = 0; it < 300; it++) begin
            a = {4'h3, 4'($urandom_range(0, 5)), 4'h0, 4'($urandom)};
            lat = $urandom_range(0, 3);
            case ($urandom_range(0, 2))
                0: do_write(a, {$urandom, $urandom, $urandom, $urandom}, cyc);
                1: do_read(a, cyc, pr);
                default: repeat ($urandom_range(1, 4)) tick();
            endcase
        end
        wait_empty();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
